// File: rtl/commit_trace_queue.sv
// Multi-lane retire-event buffer: packs up to COMMITS retired instructions per cycle into
// a tagged FIFO and drains one entry per cycle to the cosim checker (first-word-fall-through).
module commit_trace_queue #(
    parameter int COMMITS = 2,
    parameter int XLEN    = 64,
    parameter int ILEN    = 32,
    parameter int DEPTH   = 16,
    parameter int SEQ_W   = 32,
    parameter int CNT_W   = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [COMMITS-1:0]        in_valid,
    input  logic [COMMITS*XLEN-1:0]   in_pc,
    input  logic [COMMITS*ILEN-1:0]   in_insn,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [ILEN-1:0]           out_insn,
    output logic [SEQ_W-1:0]          out_seq,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic [$clog2(DEPTH):0]    high_water,
    output logic                      overflow,
    output logic [CNT_W-1:0]          enq_cnt,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int OCC_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LANE_W = $clog2(COMMITS + 1);
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    // NOTE: the entry storage has no reset; out_* never expose it while empty, so
    // clearing it would only cost reset fan-out.
    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [ILEN-1:0]  insn_mem [DEPTH];
    logic [SEQ_W-1:0] seq_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d, hw_q, hw_d;
    logic [SEQ_W-1:0] next_seq_q, next_seq_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] enq_q, enq_d, drop_q, drop_d, stall_q, stall_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic [ILEN-1:0]  last_insn_q, last_insn_d;
    logic [SEQ_W-1:0] last_seq_q, last_seq_d;

    logic [LANE_W-1:0] n;
    logic [LANE_W-1:0] lane_off [COMMITS];
    logic [PTR_W-1:0]  wr_addr  [COMMITS];
    logic [OCC_W:0]    free_slots;
    logic              deq, fits, accept, drop;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    // Each valid lane's slot offset is the number of valid lanes below it.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
        n = '0;
        for (int i = 0; i < COMMITS; i++) begin
            lane_off[i] = n;
            wr_addr[i]  = (wr_ptr_q + PTR_W'(n)) & PTR_MASK;
            n           = n + LANE_W'(in_valid[i]);
        end
    end

    assign out_valid  = (occ_q != '0);
    assign deq        = out_valid && out_ready;
    assign free_slots = (OCC_W+1)'(DEPTH) - {1'b0, occ_q} + (OCC_W+1)'(deq);
    assign fits       = ((OCC_W+1)'(n) <= free_slots);
    assign accept     = !clear && fits;
    assign drop       = !clear && !fits;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        next_seq_d  = next_seq_q;
        ovf_d       = ovf_q;
        enq_d       = enq_q;
        drop_d      = drop_q;
        stall_d     = stall_q;
        last_pc_d   = out_valid ? pc_mem[rd_ptr_q]   : last_pc_q;
        last_insn_d = out_valid ? insn_mem[rd_ptr_q] : last_insn_q;
        last_seq_d  = out_valid ? seq_mem[rd_ptr_q]  : last_seq_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            rd_ptr_d = (rd_ptr_q + PTR_W'(deq)) & PTR_MASK;
            occ_d    = occ_q - OCC_W'(deq);
            if (accept) begin
                wr_ptr_d   = (wr_ptr_q + PTR_W'(n)) & PTR_MASK;
                occ_d      = occ_q - OCC_W'(deq) + OCC_W'(n);
                next_seq_d = next_seq_q + SEQ_W'(n);
                enq_d      = sat_add(enq_q, n);
            end
            if (drop) begin
                ovf_d  = 1'b1;
                drop_d = sat_add(drop_q, n);
            end
            if (out_valid && !out_ready) begin
                stall_d = sat_add(stall_q, LANE_W'(1));
            end
        end
        hw_d = (occ_d > hw_q) ? occ_d : hw_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            hw_q        <= '0;
            next_seq_q  <= '0;
            ovf_q       <= 1'b0;
            enq_q       <= '0;
            drop_q      <= '0;
            stall_q     <= '0;
            last_pc_q   <= '0;
            last_insn_q <= '0;
            last_seq_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            hw_q        <= hw_d;
            next_seq_q  <= next_seq_d;
            ovf_q       <= ovf_d;
            enq_q       <= enq_d;
            drop_q      <= drop_d;
            stall_q     <= stall_d;
            last_pc_q   <= last_pc_d;
            last_insn_q <= last_insn_d;
            last_seq_q  <= last_seq_d;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (in_valid[i]) begin
                    pc_mem[wr_addr[i]]   <= in_pc[i*XLEN +: XLEN];
                    insn_mem[wr_addr[i]] <= in_insn[i*ILEN +: ILEN];
                    seq_mem[wr_addr[i]]  <= next_seq_q + SEQ_W'(lane_off[i]);
                end
            end
        end
    end

    // While empty the head holds whatever was last presented.
    assign out_pc     = out_valid ? pc_mem[rd_ptr_q]   : last_pc_q;
    assign out_insn   = out_valid ? insn_mem[rd_ptr_q] : last_insn_q;
    assign out_seq    = out_valid ? seq_mem[rd_ptr_q]  : last_seq_q;
    assign occupancy  = occ_q;
    assign high_water = hw_q;
    assign overflow   = ovf_q;
    assign enq_cnt    = enq_q;
    assign drop_cnt   = drop_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Scoreboard bench for commit_trace_queue: a queue-based reference model predicts the drained
// stream and status counters; a negedge monitor compares every presented head entry.
module tb_commit_trace_queue;

    localparam int COMMITS = 2;
    localparam int XLEN    = 64;
    localparam int ILEN    = 32;
    localparam int DEPTH   = 16;
    localparam int SEQ_W   = 32;
    localparam int CNT_W   = 64;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    clear;
    logic [COMMITS-1:0]      in_valid;
    logic [COMMITS*XLEN-1:0] in_pc;
    logic [COMMITS*ILEN-1:0] in_insn;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_pc;
    logic [ILEN-1:0]         out_insn;
    logic [SEQ_W-1:0]        out_seq;
    logic [$clog2(DEPTH):0]  occupancy;
    logic [$clog2(DEPTH):0]  high_water;
    logic                    overflow;
    logic [CNT_W-1:0]        enq_cnt, drop_cnt, stall_cnt;

    commit_trace_queue #(
        .COMMITS(COMMITS), .XLEN(XLEN), .ILEN(ILEN),
        .DEPTH(DEPTH), .SEQ_W(SEQ_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_seq(out_seq),
        .occupancy(occupancy), .high_water(high_water), .overflow(overflow),
        .enq_cnt(enq_cnt), .drop_cnt(drop_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] insn;
        logic [31:0] seq;
    } ent_t;

    ent_t sb[$];
    ent_t pend[$];
    ent_t last_e = '{pc: 64'h0, insn: 32'h0, seq: 32'h0};

    int total = 0;
    int bad   = 0;

    logic [31:0]     m_seq;
    longint unsigned m_enq, m_drop, m_stall;
    int              m_hw;
    bit              m_ovf;
    bit              clr_prev;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        pend.delete();
        last_e   = '{pc: 64'h0, insn: 32'h0, seq: 32'h0};
        m_seq    = '0;
        m_enq    = 0;
        m_drop   = 0;
        m_stall  = 0;
        m_hw     = 0;
        m_ovf    = 1'b0;
        clr_prev = 1'b0;
    endtask

    // Monitor: compares the presented head against the expected stream, pops on a handshake.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            check("out_valid", 64'(out_valid), 64'd1);
            check("out_pc", out_pc, sb[0].pc);
            check("out_insn", 64'(out_insn), 64'(sb[0].insn));
            check("out_seq", 64'(out_seq), 64'(sb[0].seq));
            last_e = sb[0];
            if (out_ready && !clear) void'(sb.pop_front());
        end else begin
            check("out_valid idle", 64'(out_valid), 64'd0);
            check("held pc", out_pc, last_e.pc);
            check("held seq", 64'(out_seq), 64'(last_e.seq));
        end
    end

    // One cycle of stimulus; first checks status left by the previous edge against the model.
    task automatic step(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                        input logic [31:0] i0, input logic [31:0] i1, input bit rdy, input bit clr);
        int occ, n, free_slots;
        @(posedge clock);
        #1;
        if (clr_prev) sb.delete();
        while (pend.size() > 0) sb.push_back(pend.pop_front());
        occ = sb.size();
        if (occ > m_hw) m_hw = occ;
        check("occupancy", 64'(occupancy), 64'(occ));
        check("high_water", 64'(high_water), 64'(m_hw));
        check("overflow", 64'(overflow), 64'(m_ovf));
        check("enq_cnt", enq_cnt, m_enq);
        check("drop_cnt", drop_cnt, m_drop);
        check("stall_cnt", stall_cnt, m_stall);

        in_valid  = v;
        in_pc     = {p1, p0};
        in_insn   = {i1, i0};
        out_ready = clr ? 1'b1 : rdy;
        clear     = clr;

        n = int'(v[0]) + int'(v[1]);
        if (clr) begin
            m_ovf = 1'b0;
        end else begin
            if (occ > 0 && !out_ready) m_stall++;
            free_slots = DEPTH - occ + ((occ > 0 && out_ready) ? 1 : 0);
            if (n <= free_slots) begin
                if (v[0]) begin pend.push_back('{pc: p0, insn: i0, seq: m_seq}); m_seq++; end
                if (v[1]) begin pend.push_back('{pc: p1, insn: i1, seq: m_seq}); m_seq++; end
                m_enq += longint'(n);
            end else begin
                m_ovf = 1'b1;
                m_drop += longint'(n);
            end
        end
        clr_prev = clr;
    endtask

    task automatic idle(input bit rdy);
        step(2'b00, 64'h0, 64'h0, 32'h0, 32'h0, rdy, 1'b0);
    endtask

    // Asserts reset between edges and checks outputs before the next edge arrives.
    task automatic do_reset();
        @(posedge clock);
        #1;
        in_valid  = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst occupancy", 64'(occupancy), 64'd0);
        check("rst high_water", 64'(high_water), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst enq_cnt", enq_cnt, 64'd0);
        check("rst drop_cnt", drop_cnt, 64'd0);
        check("rst stall_cnt", stall_cnt, 64'd0);
        check("rst out_pc", out_pc, 64'd0);
        check("rst out_seq", 64'(out_seq), 64'd0);
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] v;
        bit rdy, clr;
        model_reset();
        reset = 1'b0; clear = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_pc = '0; in_insn = '0;
        #1;
        check("init out_valid", 64'(out_valid), 64'd0);
        check("init out_pc", out_pc, 64'd0);
        check("init occupancy", 64'(occupancy), 64'd0);
        #20;
        reset = 1'b1;

        // Two lanes, drained in order with seq 0 then 1.
        step(2'b11, 64'h8000_0000, 64'h8000_0004, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1); idle(1'b1);
        check("two-lane enq_cnt", enq_cnt, 64'd2);
        check("two-lane drained", 64'(occupancy), 64'd0);

        // Only lane 1 valid: single entry, seq 0.
        do_reset();
        step(2'b10, 64'hdead_beef, 64'h1000, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1);
        check("lane1 enq_cnt", enq_cnt, 64'd1);

        // Fill to DEPTH, accept through same-cycle dequeue, then drop a group.
        do_reset();
        for (int k = 0; k < 8; k++)
            step(2'b11, 64'h4000 + 64'(16*k), 64'h4008 + 64'(16*k), $urandom, $urandom, 1'b0, 1'b0);
        step(2'b01, 64'h5000, 64'h0, 32'h5555_0000, 32'h0, 1'b1, 1'b0);
        check("full occupancy", 64'(occupancy), 64'd16);
        check("full high_water", 64'(high_water), 64'd16);
        check("full stall_cnt", stall_cnt, 64'd7);
        step(2'b11, 64'h6000, 64'h6004, 32'h6666_0000, 32'h6666_0001, 1'b0, 1'b0);
        check("deq-accept occupancy", 64'(occupancy), 64'd16);
        check("deq-accept no overflow", 64'(overflow), 64'd0);
        idle(1'b0);
        check("drop overflow", 64'(overflow), 64'd1);
        check("drop drop_cnt", drop_cnt, 64'd2);
        check("drop occupancy", 64'(occupancy), 64'd16);
        for (int k = 0; k < 18; k++) idle(1'b1);

        // Clear at occupancy 5 keeps counters and the tag sequence.
        do_reset();
        step(2'b11, 64'h7000, 64'h7004, $urandom, $urandom, 1'b0, 1'b0);
        step(2'b11, 64'h7008, 64'h700c, $urandom, $urandom, 1'b0, 1'b0);
        step(2'b01, 64'h7010, 64'h0, $urandom, 32'h0, 1'b0, 1'b0);
        step(2'b11, 64'h7014, 64'h7018, $urandom, $urandom, 1'b1, 1'b1);
        step(2'b01, 64'h2000, 64'h0, 32'h2000_0013, 32'h0, 1'b1, 1'b0);
        check("clear occupancy", 64'(occupancy), 64'd0);
        check("clear overflow", 64'(overflow), 64'd0);
        check("clear enq_cnt", enq_cnt, 64'd5);
        idle(1'b1); idle(1'b1);

        // Asynchronous reset in the middle of a burst; tags restart at 0.
        step(2'b11, 64'h9000, 64'h9004, $urandom, $urandom, 1'b0, 1'b0);
        step(2'b11, 64'h9008, 64'h900c, $urandom, $urandom, 1'b0, 1'b0);
        step(2'b11, 64'h9010, 64'h9014, $urandom, $urandom, 1'b0, 1'b0);
        do_reset();
        step(2'b01, 64'h3000, 64'h0, 32'h3000_0013, 32'h0, 1'b1, 1'b0);
        idle(1'b1); idle(1'b1);

        // Randomized traffic alternating drain-heavy and stall-heavy phases.
        for (int k = 0; k < 800; k++) begin
            v   = 2'($urandom);
            rdy = ($urandom % 100) < (((k / 100) % 2 == 0) ? 85 : 20);
            clr = ($urandom % 60) == 0;
            step(v, {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, rdy, clr);
        end
        for (int k = 0; k < 20; k++) idle(1'b1);
        check("final drained", 64'(occupancy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
